// File: rtl/lnrv_icb_pkg.sv
// Shared definitions for the ICB router family: target-index and width
// helpers plus default ILM/DLM region constants.
package lnrv_icb_pkg;

    localparam logic [31:0] LNRV_ILM_BASE = 32'h0000_0000;
    localparam logic [31:0] LNRV_ILM_SIZE = 32'h0002_0000;
    localparam logic [31:0] LNRV_DLM_BASE = 32'h0002_0000;
    localparam logic [31:0] LNRV_DLM_SIZE = 32'h0002_0000;

    // The error responder sits one index past the last real slave.
    function automatic int err_tgt(input int n);
        return n;
    endfunction

    function automatic int tgt_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/lnrv_ots_fifo.sv
// In-order FIFO of target IDs for outstanding ICB transactions.
// Push is ignored when full, pop is ignored when empty.
module lnrv_ots_fifo
    import lnrv_icb_pkg::*;
#(
    parameter int P_DEPTH = 4,
    parameter int P_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic [P_WIDTH-1:0]          din_i,
    output logic [P_WIDTH-1:0]          dout_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [$clog2(P_DEPTH):0]    count_o
);

    localparam int PW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
    localparam int CW = cnt_width(P_DEPTH);

    logic [P_WIDTH-1:0] mem_q [P_DEPTH];
    logic [PW-1:0]      wr_q, wr_d;
    logic [PW-1:0]      rd_q, rd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(P_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CW'(P_DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
        rd_d  = do_pop ? ptr_inc(rd_q) : rd_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/lnrv_icb_router.sv
// 1-to-N ICB address router with in-order response return and a
// built-in error responder for unmapped addresses.
module lnrv_icb_router
    import lnrv_icb_pkg::*;
#(
    parameter int                      P_ADDR_WIDTH = 32,
    parameter int                      P_DATA_WIDTH = 32,
    parameter int                      P_ICB_COUNT  = 3,
    parameter int                      P_OTS_COUNT  = 4,
    parameter logic [P_DATA_WIDTH-1:0] P_ERR_RDATA  = '0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  m_icb_cmd_vld,
    output logic                                  m_icb_cmd_rdy,
    input  logic                                  m_icb_cmd_write,
    input  logic [P_ADDR_WIDTH-1:0]               m_icb_cmd_addr,
    input  logic [P_DATA_WIDTH-1:0]               m_icb_cmd_wdata,
    input  logic [P_DATA_WIDTH/8-1:0]             m_icb_cmd_wstrb,
    output logic                                  m_icb_rsp_vld,
    input  logic                                  m_icb_rsp_rdy,
    output logic [P_DATA_WIDTH-1:0]               m_icb_rsp_rdata,
    output logic                                  m_icb_rsp_err,
    output logic [P_ICB_COUNT-1:0]                sn_icb_cmd_vld,
    input  logic [P_ICB_COUNT-1:0]                sn_icb_cmd_rdy,
    output logic [P_ICB_COUNT-1:0]                sn_icb_cmd_write,
    output logic [P_ICB_COUNT*P_ADDR_WIDTH-1:0]   sn_icb_cmd_addr,
    output logic [P_ICB_COUNT*P_DATA_WIDTH-1:0]   sn_icb_cmd_wdata,
    output logic [P_ICB_COUNT*P_DATA_WIDTH/8-1:0] sn_icb_cmd_wstrb,
    input  logic [P_ICB_COUNT-1:0]                sn_icb_rsp_vld,
    output logic [P_ICB_COUNT-1:0]                sn_icb_rsp_rdy,
    input  logic [P_ICB_COUNT-1:0]                sn_icb_rsp_err,
    input  logic [P_ICB_COUNT*P_DATA_WIDTH-1:0]   sn_icb_rsp_rdata,
    input  logic [P_ICB_COUNT*P_ADDR_WIDTH-1:0]   sn_region_base,
    input  logic [P_ICB_COUNT*P_ADDR_WIDTH-1:0]   sn_region_end,
    output logic [$clog2(P_OTS_COUNT):0]          ots_cnt,
    output logic                                  dec_err
);

    localparam int N  = P_ICB_COUNT;
    localparam int AW = P_ADDR_WIDTH;
    localparam int DW = P_DATA_WIDTH;
    localparam int TW = tgt_width(N);
    localparam logic [TW-1:0] ERR = TW'(err_tgt(N));

    logic [TW-1:0] tgt, head;
    logic [TW-1:0] last_q, last_d;
    logic          dec_err_q, dec_err_d;
    logic          full, empty, allow, slv_rdy, accept, pop;

    assign sn_icb_cmd_write = {N{m_icb_cmd_write}};
    assign sn_icb_cmd_addr  = {N{m_icb_cmd_addr}};
    assign sn_icb_cmd_wdata = {N{m_icb_cmd_wdata}};
    assign sn_icb_cmd_wstrb = {N{m_icb_cmd_wstrb}};
    assign dec_err          = dec_err_q;

    // Descending scan so the lowest matching slot wins on overlap.
    always_comb begin
        tgt = ERR;
        for (int i = N - 1; i >= 0; i--) begin
            if (sn_region_base[i*AW +: AW] <= m_icb_cmd_addr &&
                m_icb_cmd_addr < sn_region_end[i*AW +: AW])
                tgt = TW'(i);
        end
    end

    // A target switch waits for the FIFO to drain so responses stay ordered.
    always_comb begin
        slv_rdy        = 1'b1;
        sn_icb_cmd_vld = '0;
        allow          = !full && (empty || tgt == last_q);
        for (int i = 0; i < N; i++) begin
            if (tgt == TW'(i)) slv_rdy = sn_icb_cmd_rdy[i];
        end
        m_icb_cmd_rdy = allow && slv_rdy;
        accept        = m_icb_cmd_vld && m_icb_cmd_rdy;
        for (int i = 0; i < N; i++) begin
            sn_icb_cmd_vld[i] = m_icb_cmd_vld && allow && (tgt == TW'(i));
        end
        last_d    = accept ? tgt : last_q;
        dec_err_d = accept && (tgt == ERR);
    end

    always_comb begin
        m_icb_rsp_vld   = 1'b0;
        m_icb_rsp_rdata = '0;
        m_icb_rsp_err   = 1'b0;
        sn_icb_rsp_rdy  = '0;
        if (!empty) begin
            if (head == ERR) begin
                m_icb_rsp_vld   = 1'b1;
                m_icb_rsp_err   = 1'b1;
                m_icb_rsp_rdata = P_ERR_RDATA;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (head == TW'(i)) begin
                        m_icb_rsp_vld     = sn_icb_rsp_vld[i];
                        m_icb_rsp_err     = sn_icb_rsp_err[i];
                        m_icb_rsp_rdata   = sn_icb_rsp_rdata[i*DW +: DW];
                        sn_icb_rsp_rdy[i] = m_icb_rsp_rdy;
                    end
                end
            end
        end
        pop = m_icb_rsp_vld && m_icb_rsp_rdy;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q    <= '0;
            dec_err_q <= 1'b0;
        end else begin
            last_q    <= last_d;
            dec_err_q <= dec_err_d;
        end
    end

    lnrv_ots_fifo #(
        .P_DEPTH (P_OTS_COUNT),
        .P_WIDTH (TW)
    ) u_ots_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (accept),
        .pop_i   (pop),
        .din_i   (tgt),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (ots_cnt)
    );

endmodule
